// File: rtl/wb_arbiter2_if.sv
// Wishbone B4 bus bundle shared by both masters and the BRAM slave.
// All signals run on the single system clock.
interface wshb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output cyc, stb, we, sel, adr, dat_ms, cti, bte,
        input  ack, err, rty, dat_sm
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_ms, cti, bte,
        output ack, err, rty, dat_sm
    );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter in front of one slave.
// The grant is registered; data, strobes and terminations pass through combinationally.
module wb_arbiter2 #(
    parameter int MAX_HOLD = 64
) (
    input  logic   clk,
    input  logic   rst,
    wshb_if.slave  wb_m0,
    wshb_if.slave  wb_m1,
    wshb_if.master wb_s
);

    localparam logic [1:0]  IDLE     = 2'd0;
    localparam logic [1:0]  GNT0     = 2'd1;
    localparam logic [1:0]  GNT1     = 2'd2;
    localparam logic [15:0] HOLD_LIM = 16'(MAX_HOLD);

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cti;
        logic [1:0]  bte;
    } wb_req_t;

    logic [1:0]  state, state_nx;
    logic        last;
    logic [15:0] hold_cnt;
    wb_req_t     req0, req1, req_sel;
    logic        term, eot, hold_hit, other_req;

    assign req0 = {wb_m0.cyc, wb_m0.stb, wb_m0.we, wb_m0.sel,
                   wb_m0.adr, wb_m0.dat_ms, wb_m0.cti, wb_m0.bte};
    assign req1 = {wb_m1.cyc, wb_m1.stb, wb_m1.we, wb_m1.sel,
                   wb_m1.adr, wb_m1.dat_ms, wb_m1.cti, wb_m1.bte};

    always_comb begin
        req_sel = '0;
        case (state)
            GNT0:    req_sel = req0;
            GNT1:    req_sel = req1;
            default: req_sel = '0;
        endcase
    end

    assign wb_s.cyc    = req_sel.cyc;
    assign wb_s.stb    = req_sel.stb;
    assign wb_s.we     = req_sel.we;
    assign wb_s.sel    = req_sel.sel;
    assign wb_s.adr    = req_sel.adr;
    assign wb_s.dat_ms = req_sel.dat;
    assign wb_s.cti    = req_sel.cti;
    assign wb_s.bte    = req_sel.bte;

    // Terminations only reach the master that owns the bus this cycle.
    assign wb_m0.ack    = (state == GNT0) & wb_s.ack;
    assign wb_m0.err    = (state == GNT0) & wb_s.err;
    assign wb_m0.rty    = (state == GNT0) & wb_s.rty;
    assign wb_m0.dat_sm = wb_s.dat_sm;
    assign wb_m1.ack    = (state == GNT1) & wb_s.ack;
    assign wb_m1.err    = (state == GNT1) & wb_s.err;
    assign wb_m1.rty    = (state == GNT1) & wb_s.rty;
    assign wb_m1.dat_sm = wb_s.dat_sm;

    // Incrementing/constant bursts (cti 001/010) never count as a boundary.
    assign term      = wb_s.ack | wb_s.err | wb_s.rty;
    assign eot       = term & ((req_sel.cti == 3'b000) | (req_sel.cti == 3'b111));
    assign hold_hit  = hold_cnt >= HOLD_LIM;
    assign other_req = ((state == GNT0) & wb_m1.cyc) | ((state == GNT1) & wb_m0.cyc);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (wb_m0.cyc && (!wb_m1.cyc || last)) state_nx = GNT0;
                else if (wb_m1.cyc)                    state_nx = GNT1;
            end
            GNT0: begin
                if (!wb_m0.cyc)                          state_nx = wb_m1.cyc ? GNT1 : IDLE;
                else if (wb_m1.cyc && hold_hit && eot)   state_nx = GNT1;
            end
            GNT1: begin
                if (!wb_m1.cyc)                          state_nx = wb_m0.cyc ? GNT0 : IDLE;
                else if (wb_m0.cyc && hold_hit && eot)   state_nx = GNT0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            hold_cnt <= 16'd0;
        end else begin
            state <= state_nx;
            if (state_nx != state && state_nx != IDLE) begin
                last     <= (state_nx == GNT1);
                hold_cnt <= 16'd0;
            end else if (other_req && hold_cnt != 16'hFFFF) begin
                hold_cnt <= hold_cnt + 16'd1;
            end
        end
    end

endmodule
